spatz_vrf_operand_collector: RTL and testbench

- Sits between the VFU issue logic and the banked vector register file read ports.
- Takes one operand-fetch request per instruction beat: vs2, vs1 and vd addresses plus a use mask.
- Drives VRF read enables, retrying every cycle until each bank grants (rvalid), since bank conflicts may deny a port.
- Gathers the granted data into a staging bundle and pushes the complete bundle into an output FIFO, drained by the VFU through a valid/ready handshake.

---
 rtl/spatz_pkg.sv | 27 ++
 rtl/fifo_v3.sv | 72 +++++++
 rtl/spatz_vrf_operand_collector.sv | 137 +++++++++++++
 tb/tb_spatz_vrf_operand_collector.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spatz_pkg.sv
// Shared Spatz types used by the VRF operand collector: register address/data types,
// operand lane indices, the collected operand bundle and the collector FSM states.
package spatz_pkg;

    localparam int unsigned VregAddrWidth = 5;
    localparam int unsigned VregDataWidth = 32;

    typedef logic [VregAddrWidth-1:0] vreg_addr_t;
    typedef logic [VregDataWidth-1:0] vreg_data_t;

    localparam int unsigned OC_VS2       = 0;
    localparam int unsigned OC_VS1       = 1;
    localparam int unsigned OC_VD        = 2;
    localparam int unsigned NrOcOperands = 3;
    localparam int unsigned OcIdWidth    = 4;

    typedef struct packed {
        vreg_data_t [NrOcOperands-1:0] data;
        logic [OcIdWidth-1:0]          id;
    } oc_bundle_t;

    typedef enum logic {
        OC_IDLE,
        OC_COLLECT
    } oc_state_e;

endpackage

// File: rtl/fifo_v3.sv
// Common-cells style FIFO with a synchronous active-low reset and flush.
// With FALL_THROUGH=0 the head entry is read straight from storage whenever not empty.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [31:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned      AddrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AddrW:0]   FullCnt = (AddrW+1)'(DEPTH);
    localparam logic [AddrW-1:0] LastPtr = AddrW'(DEPTH-1);

    dtype             mem_q [DEPTH];
    logic [AddrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AddrW:0]   cnt_q, cnt_d;
    logic             wr, rd;

    assign full_o = (cnt_q == FullCnt);

    // An empty fall-through FIFO hands a simultaneous push straight to the reader.
    always_comb begin
        data_o  = mem_q[rptr_q];
        empty_o = (cnt_q == '0);
        wr      = push_i & (cnt_q != FullCnt);
        rd      = pop_i & (cnt_q != '0);
        if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
            data_o  = data_i;
            empty_o = 1'b0;
            if (pop_i) begin
                wr = 1'b0;
                rd = 1'b0;
            end
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (wr) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
        if (rd) rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
        if (wr && !rd) cnt_d = cnt_q + 1'b1;
        else if (!wr && rd) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/spatz_vrf_operand_collector.sv
// Fetches vs2/vs1/vd from the banked VRF, retrying denied ports, and queues complete
// operand bundles for the VFU. Define SPATZ_VRF_OC_STATS_EN to add conflict_cnt_o.
module spatz_vrf_operand_collector
    import spatz_pkg::*;
#(
    parameter int unsigned NrOperands = NrOcOperands,
    parameter int unsigned Depth      = 2,
    parameter int unsigned IdWidth    = OcIdWidth
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic                                            req_valid_i,
    output logic                                            req_ready_o,
    input  logic [NrOperands-1:0][$bits(vreg_addr_t)-1:0]   req_addr_i,
    input  logic [NrOperands-1:0]                           req_use_i,
    input  logic [IdWidth-1:0]                              req_id_i,
    output logic [NrOperands-1:0][$bits(vreg_addr_t)-1:0]   vrf_raddr_o,
    output logic [NrOperands-1:0]                           vrf_re_o,
    input  logic [NrOperands-1:0][$bits(vreg_data_t)-1:0]   vrf_rdata_i,
    input  logic [NrOperands-1:0]                           vrf_rvalid_i,
    output logic                                            op_valid_o,
    input  logic                                            op_ready_i,
    output logic [NrOperands-1:0][$bits(vreg_data_t)-1:0]   op_data_o,
    output logic [IdWidth-1:0]                              op_id_o
`ifdef SPATZ_VRF_OC_STATS_EN
    ,
    output logic [31:0]                                     conflict_cnt_o
`endif
);

    oc_state_e                    state_q, state_d;
    vreg_addr_t [NrOperands-1:0]  addr_q, addr_d;
    vreg_data_t [NrOperands-1:0]  stage_q, stage_d, stage_merged;
    logic [NrOperands-1:0]        pending_q, pending_d, grant;
    logic [IdWidth-1:0]           id_q, id_d;
    logic                         fifo_full, fifo_empty, push, pop, accept, complete;
    oc_bundle_t                   push_bundle, pop_bundle;

    // Reads depend only on registered state, so grants can never feed back into enables.
    assign vrf_re_o = (state_q == OC_COLLECT) ? (pending_q & {NrOperands{!fifo_full}}) : '0;
    assign grant    = vrf_re_o & vrf_rvalid_i;
    assign complete = (state_q == OC_COLLECT) && ((pending_q & ~grant) == '0) && !fifo_full;
    assign accept   = req_valid_i & req_ready_o;

    always_comb begin
        for (int k = 0; k < NrOperands; k++) begin
            stage_merged[k] = grant[k] ? vreg_data_t'(vrf_rdata_i[k]) : stage_q[k];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= OC_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            OC_IDLE:    if (accept) state_d = OC_COLLECT;
            OC_COLLECT: if (complete && !accept) state_d = OC_IDLE;
            default:    state_d = OC_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == OC_IDLE) || complete;
        vrf_raddr_o = (state_q == OC_COLLECT) ? addr_q : '0;
        push        = complete;
    end

    // A newly accepted request overwrites the bundle that is being pushed on the same edge.
    always_comb begin
        addr_d    = addr_q;
        id_d      = id_q;
        pending_d = pending_q & ~grant;
        stage_d   = stage_merged;
        if (accept) begin
            addr_d    = req_addr_i;
            id_d      = req_id_i;
            pending_d = req_use_i;
            stage_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            addr_q    <= '0;
            id_q      <= '0;
            pending_q <= '0;
            stage_q   <= '0;
        end else begin
            addr_q    <= addr_d;
            id_q      <= id_d;
            pending_q <= pending_d;
            stage_q   <= stage_d;
        end
    end

    assign push_bundle.data = stage_merged;
    assign push_bundle.id   = id_q;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (Depth),
        .dtype        (oc_bundle_t)
    ) i_out_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (push_bundle),
        .push_i  (push),
        .data_o  (pop_bundle),
        .pop_i   (pop)
    );

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign op_valid_o = !fifo_empty;
    assign pop        = op_valid_o & op_ready_i;
    assign op_data_o  = fifo_empty ? '0 : pop_bundle.data;
    assign op_id_o    = fifo_empty ? '0 : pop_bundle.id;

`ifdef SPATZ_VRF_OC_STATS_EN
    logic [31:0] conflict_cnt_q;
    logic        conflict;

    assign conflict       = |(vrf_re_o & ~vrf_rvalid_i);
    assign conflict_cnt_o = conflict_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni)                                    conflict_cnt_q <= '0;
        else if (conflict && (conflict_cnt_q != '1))    conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
`endif

endmodule

// File: tb/tb_spatz_vrf_operand_collector.sv
// Self-checking bench for spatz_vrf_operand_collector: directed vector table, hand-written
// conflict/backpressure/reset sequences and a randomized run against a scoreboard queue.
module tb_spatz_vrf_operand_collector;
   import spatz_pkg::*;

   localparam int N     = 3;
   localparam int IdW   = 4;
   localparam int AW    = $bits(vreg_addr_t);
   localparam int DW    = $bits(vreg_data_t);

   typedef struct {
      logic [N-1:0]         useMask;
      logic [N-1:0][AW-1:0] addr;
      logic [IdW-1:0]       id;
      logic [N*DW-1:0]      expData;
   } vec_t;

   typedef struct {
      logic [N*DW-1:0] data;
      logic [IdW-1:0]  id;
   } bundle_t;

   logic                 clk = 1'b0;
   logic                 rstN;
   logic                 reqValid, reqReady;
   logic [N-1:0][AW-1:0] reqAddr;
   logic [N-1:0]         reqUse;
   logic [IdW-1:0]       reqId;
   logic [N-1:0][AW-1:0] vrfRaddr;
   logic [N-1:0]         vrfRe;
   logic [N-1:0][DW-1:0] vrfRdata;
   logic [N-1:0]         vrfRvalid;
   logic                 opValid, opReady;
   logic [N-1:0][DW-1:0] opData;
   logic [IdW-1:0]       opId;
   logic [N-1:0]         grantMask;
`ifdef SPATZ_VRF_OC_STATS_EN
   logic [31:0]          conflictCnt;
`endif

   int checks = 0;
   int passed = 0;

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   spatz_vrf_operand_collector #(
      .NrOperands (N),
      .Depth      (2),
      .IdWidth    (IdW)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rstN),
      .req_valid_i  (reqValid),
      .req_ready_o  (reqReady),
      .req_addr_i   (reqAddr),
      .req_use_i    (reqUse),
      .req_id_i     (reqId),
      .vrf_raddr_o  (vrfRaddr),
      .vrf_re_o     (vrfRe),
      .vrf_rdata_i  (vrfRdata),
      .vrf_rvalid_i (vrfRvalid),
      .op_valid_o   (opValid),
      .op_ready_i   (opReady),
      .op_data_o    (opData),
      .op_id_o      (opId)
`ifdef SPATZ_VRF_OC_STATS_EN
      ,
      .conflict_cnt_o (conflictCnt)
`endif
   );

   // Register file contents are a fixed function of the address so expected data is easy to derive.
   function automatic vreg_data_t memVal(vreg_addr_t a);
      return 32'hA500_0000 | ({27'b0, a} * 32'h0001_0203);
   endfunction

   function automatic logic [N*DW-1:0] expData(logic [N-1:0] u, logic [N-1:0][AW-1:0] a);
      logic [N-1:0][DW-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++) if (u[k]) r[k] = memVal(a[k]);
      return r;
   endfunction

   // Behavioural VRF: data follows the address, grants come from a per-cycle bank mask
   // that is deliberately not qualified by the read enable.
   for (genvar k = 0; k < N; k++) begin : gVrf
      assign vrfRdata[k] = memVal(vrfRaddr[k]);
   end
   assign vrfRvalid = grantMask;

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual === expected) passed++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
   endtask

   task automatic applyStimulus(input logic v, input logic [N-1:0] u, input logic [N-1:0][AW-1:0] a,
                                input logic [IdW-1:0] id);
      reqValid = v;
      reqUse   = u;
      reqAddr  = a;
      reqId    = id;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      applyStimulus(1'b0, '0, '0, '0);
      opReady   = 1'b0;
      grantMask = '0;
      rstN      = 1'b0;
      stepCycle();
      stepCycle();
      rstN      = 1'b1;
   endtask

   vec_t              vecs[6];
   bundle_t           scoreboard[$];
   bundle_t           exp;
   logic [N-1:0][AW-1:0] bb[4];
   int                idx;

   // Safety net in case a sequence locks up.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      reqValid = 1'b0; reqUse = '0; reqAddr = '0; reqId = '0;
      opReady = 1'b0; grantMask = '0; rstN = 1'b0;

      vecs[0] = '{3'b111, {5'd12, 5'd7, 5'd3},  4'd5,  '0};
      vecs[1] = '{3'b010, {5'd3,  5'd2, 5'd1},  4'd9,  '0};
      vecs[2] = '{3'b000, {5'd9,  5'd8, 5'd7},  4'd1,  '0};
      vecs[3] = '{3'b101, {5'd31, 5'd0, 5'd17}, 4'd15, '0};
      vecs[4] = '{3'b100, {5'd20, 5'd21, 5'd22}, 4'd6, '0};
      vecs[5] = '{3'b011, {5'd4,  5'd30, 5'd29}, 4'd10, '0};
      foreach (vecs[i]) vecs[i].expData = expData(vecs[i].useMask, vecs[i].addr);

      // Reset state
      doReset();
      #1;
      checkOutput("rst_req_ready", reqReady, 1);
      checkOutput("rst_vrf_re", vrfRe, 0);
      checkOutput("rst_vrf_raddr", vrfRaddr, 0);
      checkOutput("rst_op_valid", opValid, 0);
      checkOutput("rst_op_data", opData, 0);
      checkOutput("rst_op_id", opId, 0);
      stepCycle();

      // Table: single requests with immediate grants, op_valid two cycles after accept
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, vecs[i].useMask, vecs[i].addr, vecs[i].id);
         opReady = 1'b1; grantMask = 3'b111;
         #1;
         checkOutput("vec_accept_ready", reqReady, 1);
         checkOutput("vec_accept_no_re", vrfRe, 0);
         stepCycle();
         applyStimulus(1'b0, '0, '0, '0);
         #1;
         checkOutput("vec_t1_re", vrfRe, vecs[i].useMask);
         checkOutput("vec_t1_raddr", vrfRaddr, vecs[i].addr);
         checkOutput("vec_t1_valid", opValid, 0);
         stepCycle();
         #1;
         checkOutput("vec_t2_valid", opValid, 1);
         checkOutput("vec_t2_data", opData, vecs[i].expData);
         checkOutput("vec_t2_id", opId, vecs[i].id);
         checkOutput("vec_t2_re", vrfRe, 0);
         stepCycle();
         #1;
         checkOutput("vec_t3_empty", opValid, 0);
      end

      // Bank conflict: vs1 denied for three cycles
      applyStimulus(1'b1, 3'b111, {5'd6, 5'd5, 5'd4}, 4'd3);
      grantMask = 3'b101; opReady = 1'b1;
      stepCycle();
      applyStimulus(1'b0, '0, '0, '0);
      for (int c = 1; c <= 4; c++) begin
         if (c == 4) grantMask = 3'b111;
         #1;
         checkOutput("cfl_re", vrfRe, (c == 1) ? 3'b111 : 3'b010);
         checkOutput("cfl_raddr_vs1", vrfRaddr[1], 5'd5);
         checkOutput("cfl_ready", reqReady, (c == 4) ? 1 : 0);
         checkOutput("cfl_no_valid", opValid, 0);
         stepCycle();
      end
      #1;
      checkOutput("cfl_valid", opValid, 1);
      checkOutput("cfl_data", opData, expData(3'b111, {5'd6, 5'd5, 5'd4}));
      checkOutput("cfl_id", opId, 4'd3);
      stepCycle();

      // Back-to-back: four requests, one bundle per cycle
      bb[0] = {5'd1, 5'd2, 5'd3};
      bb[1] = {5'd10, 5'd11, 5'd12};
      bb[2] = {5'd20, 5'd21, 5'd22};
      bb[3] = {5'd27, 5'd28, 5'd30};
      grantMask = 3'b111; opReady = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c < 4) applyStimulus(1'b1, 3'b111, bb[c], IdW'(c + 2));
         else       applyStimulus(1'b0, '0, '0, '0);
         #1;
         if (c < 4) checkOutput("b2b_ready", reqReady, 1);
         if (c >= 2) begin
            checkOutput("b2b_valid", opValid, 1);
            checkOutput("b2b_data", opData, expData(3'b111, bb[c-2]));
            checkOutput("b2b_id", opId, c);
         end
         stepCycle();
      end
      #1;
      checkOutput("b2b_drained", opValid, 0);

      // Backpressure: two bundles fill the FIFO, third request waits with reads withheld
      opReady = 1'b0; grantMask = 3'b111;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b1, 3'b111, bb[c], IdW'(c + 8));
         #1;
         checkOutput("bp_accept_ready", reqReady, 1);
         stepCycle();
      end
      applyStimulus(1'b0, '0, '0, '0);
      for (int c = 0; c < 2; c++) begin
         #1;
         checkOutput("bp_full_re", vrfRe, 0);
         checkOutput("bp_full_ready", reqReady, 0);
         checkOutput("bp_head_data", opData, expData(3'b111, bb[0]));
         stepCycle();
      end
      opReady = 1'b1;
      #1;
      checkOutput("bp_pop_still_blocked", vrfRe, 0);
      idx = 0;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) #1;
         if (opValid && idx < 3) begin
            checkOutput("bp_data", opData, expData(3'b111, bb[idx]));
            checkOutput("bp_id", opId, idx + 8);
            idx++;
         end
         stepCycle();
      end
      checkOutput("bp_count", idx, 3);

      // Reset mid-COLLECT with one bundle held in the FIFO
      opReady = 1'b0; grantMask = 3'b111;
      applyStimulus(1'b1, 3'b111, bb[1], 4'd4);
      stepCycle();
      applyStimulus(1'b1, 3'b011, bb[2], 4'd7);
      stepCycle();
      applyStimulus(1'b0, '0, '0, '0);
      grantMask = 3'b000;
      #1;
      checkOutput("mid_fifo_held", opValid, 1);
      checkOutput("mid_re", vrfRe, 3'b011);
      rstN = 1'b0;
      stepCycle();
      checkOutput("mid_rst_valid", opValid, 0);
      checkOutput("mid_rst_re", vrfRe, 0);
      checkOutput("mid_rst_ready", reqReady, 1);
      checkOutput("mid_rst_data", opData, 0);
      rstN = 1'b1;
      stepCycle();

`ifdef SPATZ_VRF_OC_STATS_EN
      // Conflict counter: five denied cycles, then cleared by reset
      doReset();
      #1;
      checkOutput("stat_reset", conflictCnt, 0);
      applyStimulus(1'b1, 3'b010, bb[0], 4'd1);
      grantMask = 3'b000;
      stepCycle();
      applyStimulus(1'b0, '0, '0, '0);
      repeat (5) stepCycle();
      checkOutput("stat_five", conflictCnt, 5);
      rstN = 1'b0;
      stepCycle();
      checkOutput("stat_after_rst", conflictCnt, 0);
      rstN = 1'b1;
      stepCycle();
`endif

      // Randomized traffic against an in-order scoreboard
      doReset();
      scoreboard.delete();
      for (int c = 0; c < 600; c++) begin
         logic [N-1:0][AW-1:0] ra;
         for (int k = 0; k < N; k++) ra[k] = AW'($urandom_range(0, 31));
         applyStimulus($urandom_range(0, 3) != 0, N'($urandom), ra, IdW'($urandom));
         grantMask = N'($urandom);
         opReady   = $urandom_range(0, 9) < 7;
         #1;
         if (opValid && opReady) begin
            checkOutput("rand_expected_pending", scoreboard.size() != 0, 1);
            if (scoreboard.size() != 0) begin
               exp = scoreboard.pop_front();
               checkOutput("rand_data", opData, exp.data);
               checkOutput("rand_id", opId, exp.id);
            end
         end
         if (reqValid && reqReady) scoreboard.push_back('{expData(reqUse, reqAddr), reqId});
         stepCycle();
      end
      applyStimulus(1'b0, '0, '0, '0);
      grantMask = 3'b111; opReady = 1'b1;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (opValid) begin
            checkOutput("drain_expected_pending", scoreboard.size() != 0, 1);
            if (scoreboard.size() != 0) begin
               exp = scoreboard.pop_front();
               checkOutput("drain_data", opData, exp.data);
               checkOutput("drain_id", opId, exp.id);
            end
         end
         stepCycle();
      end
      checkOutput("rand_all_delivered", scoreboard.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
